// File: rtl/mempool_ctrl_regfile.sv
// mempool_ctrl_regfile
//   AXI-Lite slave holding the MemPool control/status registers. It reports
//   the TCDM geometry and core count, produces per-core wake-up pulses and
//   holds the end-of-computation (EOC) word. Reads and writes are served by
//   two independent FSMs. Each FSM allows one outstanding transaction.
//
// Register map (decoded on addr[7:2]):
//   0x00 TCDM_START RO | 0x04 TCDM_END RO | 0x08 NUM_CORES RO
//   0x0C WAKE_UP    RW | 0x10 EOC      RW | 0x14..0xFC unmapped (SLVERR)
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous reset, active-high
//   axi_lite_req_i  AXI-Lite request  (aw, w, b_ready, ar, r_ready + valids)
//   axi_lite_resp_o AXI-Lite response (readies, b, b_valid, r, r_valid)
//   wake_up_o       one-cycle wake pulse per core
//   eoc_o           EOC register value
//   eoc_valid_o     EOC register bit 0

package mempool_ctrl_regfile_pkg;
    typedef struct packed {
        logic [31:0] addr;
    } axi_lite_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } axi_lite_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_lite_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } axi_lite_r_t;

    typedef struct packed {
        axi_lite_ax_t aw;
        logic         aw_valid;
        axi_lite_w_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_lite_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         w_ready;
        axi_lite_b_t  b;
        logic         b_valid;
        logic         ar_ready;
        axi_lite_r_t  r;
        logic         r_valid;
    } axi_lite_resp_t;
endpackage

module mempool_ctrl_regfile
    import mempool_ctrl_regfile_pkg::*;
#(
    parameter int unsigned NumCores     = 256,
    parameter logic [31:0] TCDMBaseAddr = 32'h0000_0000,
    parameter logic [31:0] TCDMSize     = 32'h0010_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  axi_lite_req_t       axi_lite_req_i,
    output axi_lite_resp_t      axi_lite_resp_o,
    output logic [NumCores-1:0] wake_up_o,
    output logic [31:0]         eoc_o,
    output logic                eoc_valid_o
);

    localparam int unsigned IdxW      = (NumCores > 1) ? $clog2(NumCores) : 1;
    localparam logic [31:0] TcdmEnd   = TCDMBaseAddr + TCDMSize;  // wraps mod 2^32
    localparam logic [31:0] NumCoresW = 32'(NumCores);

    localparam logic [5:0] OffStart  = 6'd0;
    localparam logic [5:0] OffEnd    = 6'd1;
    localparam logic [5:0] OffCores  = 6'd2;
    localparam logic [5:0] OffWake   = 6'd3;
    localparam logic [5:0] OffEoc    = 6'd4;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [31:0]         wake_reg_q, eoc_q;
    logic [NumCores-1:0] wake_pulse_q, wake_pulse_d;
    logic [1:0]          b_resp_q, b_resp_d;
    logic [31:0]         r_data_q, r_data_d;
    logic [1:0]          r_resp_q, r_resp_d;

    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic        write_hs;
    logic [5:0]  w_off, r_off;
    logic [31:0] wmask, wake_merged, eoc_merged;

    // Address bits outside [7:2] play no part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_lite_req_i.aw.addr[31:8], axi_lite_req_i.aw.addr[1:0],
                                axi_lite_req_i.ar.addr[31:8], axi_lite_req_i.ar.addr[1:0]};

    assign w_off = axi_lite_req_i.aw.addr[7:2];
    assign r_off = axi_lite_req_i.ar.addr[7:2];

    // Expand byte strobes into a bit mask and merge into the RW registers.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{axi_lite_req_i.w.strb[i]}};
        end
    end

    assign wake_merged = (wake_reg_q & ~wmask) | (axi_lite_req_i.w.data & wmask);
    assign eoc_merged  = (eoc_q      & ~wmask) | (axi_lite_req_i.w.data & wmask);

    // Write FSM: address and data must arrive together to be accepted.
    always_comb begin
        w_state_d = w_state_q;
        b_resp_d  = b_resp_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        write_hs  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready = axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid;
                w_ready  = axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid;
                if (axi_lite_req_i.aw_valid && axi_lite_req_i.w_valid) begin
                    write_hs  = 1'b1;
                    b_resp_d  = (w_off <= OffEoc) ? RespOkay : RespSlvErr;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (axi_lite_req_i.b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Wake decode: all-ones broadcasts, an in-range index selects one core.
    always_comb begin
        wake_pulse_d = '0;
        if (write_hs && (w_off == OffWake)) begin
            if (wake_merged == 32'hFFFF_FFFF) begin
                wake_pulse_d = '1;
            end else if (wake_merged < NumCoresW) begin
                wake_pulse_d[wake_merged[IdxW-1:0]] = 1'b1;
            end
        end
    end

    // Read FSM: data is captured at the AR handshake, so a write landing on
    // the same edge is not yet visible to that read.
    always_comb begin
        r_state_d = r_state_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (axi_lite_req_i.ar_valid) begin
                    r_resp_d  = RespOkay;
                    unique case (r_off)
                        OffStart: r_data_d = TCDMBaseAddr;
                        OffEnd:   r_data_d = TcdmEnd;
                        OffCores: r_data_d = NumCoresW;
                        OffWake:  r_data_d = wake_reg_q;
                        OffEoc:   r_data_d = eoc_q;
                        default: begin
                            r_data_d = '0;
                            r_resp_d = RespSlvErr;
                        end
                    endcase
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid = 1'b1;
                if (axi_lite_req_i.r_ready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control state, registers and wake pulse: cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            wake_reg_q   <= '0;
            eoc_q        <= '0;
            wake_pulse_q <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            wake_pulse_q <= wake_pulse_d;
            if (write_hs && (w_off == OffWake)) begin
                wake_reg_q <= wake_merged;
            end
            if (write_hs && (w_off == OffEoc)) begin
                eoc_q <= eoc_merged;
            end
        end
    end

    // Response payloads: only meaningful while the matching valid is high.
    always_ff @(posedge clk_i) begin
        b_resp_q <= b_resp_d;
        r_data_q <= r_data_d;
        r_resp_q <= r_resp_d;
    end

    always_comb begin
        axi_lite_resp_o          = '0;
        axi_lite_resp_o.aw_ready = aw_ready;
        axi_lite_resp_o.w_ready  = w_ready;
        axi_lite_resp_o.b.resp   = b_resp_q;
        axi_lite_resp_o.b_valid  = b_valid;
        axi_lite_resp_o.ar_ready = ar_ready;
        axi_lite_resp_o.r.data   = r_data_q;
        axi_lite_resp_o.r.resp   = r_resp_q;
        axi_lite_resp_o.r_valid  = r_valid;
    end

    assign wake_up_o   = wake_pulse_q;
    assign eoc_o       = eoc_q;
    assign eoc_valid_o = eoc_q[0];

endmodule

// File: tb/tb_mempool_ctrl_regfile.sv
// Testbench for mempool_ctrl_regfile: directed scenarios plus randomized
// accesses checked against a behavioural register-map model.
module tb_mempool_ctrl_regfile;
    import mempool_ctrl_regfile_pkg::*;

    localparam int NC = 256;

    logic           clk = 1'b0;
    logic           rst;
    axi_lite_req_t  req;
    axi_lite_resp_t rsp;
    logic [NC-1:0]  wake;
    logic [31:0]    eoc;
    logic           eoc_valid;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_wake;
    logic [31:0] m_eoc;

    always #5 clk = ~clk;

    mempool_ctrl_regfile #(
        .NumCores    (NC),
        .TCDMBaseAddr(32'h0000_0000),
        .TCDMSize    (32'h0010_0000)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .axi_lite_req_i (req),
        .axi_lite_resp_o(rsp),
        .wake_up_o      (wake),
        .eoc_o          (eoc),
        .eoc_valid_o    (eoc_valid)
    );

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) res[8*b +: 8] = d[8*b +: 8];
        return res;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s, output logic [1:0] resp,
                                        output logic [NC-1:0] pulse);
        int unsigned off;
        off   = (a >> 2) % 64;
        pulse = '0;
        resp  = 2'b00;
        if (off == 3) begin
            m_wake = merge(m_wake, d, s);
            if (m_wake == 32'hFFFF_FFFF) pulse = '1;
            else if (m_wake < NC) pulse[m_wake] = 1'b1;
        end else if (off == 4) begin
            m_eoc = merge(m_eoc, d, s);
        end else if (off > 4) begin
            resp = 2'b10;
        end
    endfunction

    function automatic void model_read(input logic [31:0] a, output logic [31:0] d,
                                       output logic [1:0] resp);
        int unsigned off;
        off  = (a >> 2) % 64;
        resp = 2'b00;
        case (off)
            0: d = 32'h0000_0000;
            1: d = 32'h0000_0000 + 32'h0010_0000;
            2: d = NC;
            3: d = m_wake;
            4: d = m_eoc;
            default: begin d = 0; resp = 2'b10; end
        endcase
    endfunction

    // Write driver: returns what was observed around the handshake edge N.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int hold, output logic [1:0] resp, output logic bv1,
                             output logic [NC-1:0] w1, output logic [NC-1:0] w2,
                             output logic [31:0] eoc1, output logic stable,
                             output logic bv_end, output logic tmo);
        req.aw.addr = a; req.w.data = d; req.w.strb = s;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
        tmo = 1'b1; stable = 1'b1; bv1 = 1'b0; resp = 2'b11; w1 = '0; w2 = '0;
        eoc1 = '0; bv_end = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp.aw_ready && rsp.w_ready) begin tmo = 1'b0; break; end
        end
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        if (tmo) return;
        bv1  = rsp.b_valid;
        resp = rsp.b.resp;
        w1   = wake;
        eoc1 = eoc;
        req.b_ready = (hold == 0);
        @(posedge clk); #1;
        w2 = wake;
        for (int i = 0; i < hold; i++) begin
            if (!rsp.b_valid || rsp.b.resp !== resp) stable = 1'b0;
            if (i == hold - 1) req.b_ready = 1'b1;
            @(posedge clk); #1;
        end
        req.b_ready = 1'b0;
        bv_end = rsp.b_valid;
    endtask

    task automatic bus_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                            output logic [1:0] resp, output logic rv1, output logic stable,
                            output logic rv_end, output logic tmo);
        req.ar.addr = a; req.ar_valid = 1'b1; req.r_ready = 1'b0;
        tmo = 1'b1; stable = 1'b1; rv1 = 1'b0; d = '0; resp = 2'b11; rv_end = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp.ar_ready) begin tmo = 1'b0; break; end
        end
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        if (tmo) return;
        rv1  = rsp.r_valid;
        d    = rsp.r.data;
        resp = rsp.r.resp;
        req.r_ready = (hold == 0);
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            if (!rsp.r_valid || rsp.r.data !== d || rsp.r.resp !== resp) stable = 1'b0;
            if (i == hold - 1) req.r_ready = 1'b1;
            @(posedge clk); #1;
        end
        req.r_ready = 1'b0;
        rv_end = rsp.r_valid;
    endtask

    task automatic test_reset();
        req = '0; rst = 1'b1;
        m_wake = '0; m_eoc = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (rsp.ar_ready !== 1'b1 || rsp.aw_ready !== 1'b0 || rsp.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_readies got ar=%b aw=%b w=%b exp 1 0 0",
                     rsp.ar_ready, rsp.aw_ready, rsp.w_ready);
        end
        checks++;
        if (rsp.b_valid !== 1'b0 || rsp.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got b=%b r=%b exp 0 0", rsp.b_valid, rsp.r_valid);
        end
        checks++;
        if (wake !== '0 || eoc !== 32'h0 || eoc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got wake=%h eoc=%h eocv=%b exp 0", wake, eoc, eoc_valid);
        end
    endtask

    task automatic test_ro_reads();
        logic [31:0] d, ed; logic [1:0] r, er; logic rv1, st, rve, tmo;
        for (int i = 0; i < 3; i++) begin
            bus_read(32'(i * 4), (i == 2) ? 3 : 0, d, r, rv1, st, rve, tmo);
            model_read(32'(i * 4), ed, er);
            checks++;
            if (tmo || d !== ed || r !== er || rv1 !== 1'b1 || rve !== 1'b0 || !st) begin
                errors++;
                $display("FAIL ro_read_%0d got data=%h resp=%b rv1=%b end=%b stable=%b tmo=%b exp data=%h resp=%b",
                         i, d, r, rv1, rve, st, tmo, ed, er);
            end
        end
    endtask

    task automatic test_wake();
        logic [31:0] vals [3] = '{32'd5, 32'hFFFF_FFFF, 32'd300};
        logic [1:0] r, er; logic [NC-1:0] w1, w2, ep; logic [31:0] e1, d, ed;
        logic bv1, st, bve, tmo, rv1, rve;
        for (int i = 0; i < 3; i++) begin
            bus_write(32'h0C, vals[i], 4'hF, 0, r, bv1, w1, w2, e1, st, bve, tmo);
            model_write(32'h0C, vals[i], 4'hF, er, ep);
            checks++;
            if (tmo || r !== er || bv1 !== 1'b1 || bve !== 1'b0) begin
                errors++;
                $display("FAIL wake_resp_%0d got resp=%b bv1=%b bend=%b tmo=%b exp resp=%b",
                         i, r, bv1, bve, tmo, er);
            end
            checks++;
            if (w1 !== ep || w2 !== '0) begin
                errors++;
                $display("FAIL wake_pulse_%0d got n1=%h n2=%h exp n1=%h n2=0", i, w1, w2, ep);
            end
        end
        bus_read(32'h0C, 0, d, r, rv1, st, rve, tmo);
        model_read(32'h0C, ed, er);
        checks++;
        if (tmo || d !== ed || d !== 32'd300 || r !== er) begin
            errors++;
            $display("FAIL wake_readback got %h/%b exp %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_eoc();
        logic [31:0] vals [4] = '{32'h1, 32'h0, 32'h1, 32'h0000_AB00};
        logic [3:0]  strbs[4] = '{4'hF, 4'hF, 4'hF, 4'b0010};
        logic [1:0] r, er; logic [NC-1:0] w1, w2, ep; logic [31:0] e1;
        logic bv1, st, bve, tmo;
        for (int i = 0; i < 4; i++) begin
            bus_write(32'h10, vals[i], strbs[i], 0, r, bv1, w1, w2, e1, st, bve, tmo);
            model_write(32'h10, vals[i], strbs[i], er, ep);
            checks++;
            if (tmo || e1 !== m_eoc || eoc_valid !== m_eoc[0] || r !== er) begin
                errors++;
                $display("FAIL eoc_write_%0d got eoc=%h valid=%b resp=%b exp eoc=%h valid=%b resp=%b",
                         i, e1, eoc_valid, r, m_eoc, m_eoc[0], er);
            end
        end
        checks++;
        if (eoc !== 32'h0000_AB01) begin
            errors++;
            $display("FAIL eoc_partial got %h exp 0000ab01", eoc);
        end
    endtask

    task automatic test_lone_valid();
        logic [1:0] er, r0; logic [NC-1:0] ep; logic bad, st;
        req.aw.addr = 32'h0C; req.w.data = 32'd7; req.w.strb = 4'hF;
        req.aw_valid = 1'b1; req.w_valid = 1'b0; req.b_ready = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp.aw_ready || rsp.w_ready) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad || rsp.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL lone_aw got early ready/bvalid=%b/%b exp 0/0", bad, rsp.b_valid);
        end
        req.w_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp.aw_ready !== 1'b1 || rsp.w_ready !== 1'b1) begin
            errors++;
            $display("FAIL both_valid_ready got aw=%b w=%b exp 1 1", rsp.aw_ready, rsp.w_ready);
        end
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        model_write(32'h0C, 32'd7, 4'hF, er, ep);
        r0 = rsp.b.resp; st = rsp.b_valid;
        checks++;
        if (wake !== ep) begin
            errors++;
            $display("FAIL lone_wake got %h exp %h", wake, ep);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (!rsp.b_valid || rsp.b.resp !== r0) st = 1'b0;
        end
        checks++;
        if (!st || r0 !== er) begin
            errors++;
            $display("FAIL b_hold got stable=%b resp=%b exp stable=1 resp=%b", st, r0, er);
        end
        req.b_ready = 1'b1;
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        checks++;
        if (rsp.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_release got bvalid=%b exp 0", rsp.b_valid);
        end
    endtask

    task automatic test_unmapped();
        logic [1:0] r, er; logic [NC-1:0] w1, w2, ep; logic [31:0] e1, d, ed;
        logic bv1, st, bve, tmo, rv1, rve;
        bus_write(32'h20, 32'h5A5A_0003, 4'hF, 0, r, bv1, w1, w2, e1, st, bve, tmo);
        model_write(32'h20, 32'h5A5A_0003, 4'hF, er, ep);
        checks++;
        if (tmo || r !== 2'b10 || w1 !== '0) begin
            errors++;
            $display("FAIL unmapped_write got resp=%b wake=%h exp resp=10 wake=0", r, w1);
        end
        bus_read(32'h20, 0, d, r, rv1, st, rve, tmo);
        checks++;
        if (tmo || r !== 2'b10 || d !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got %h/%b exp 0/10", d, r);
        end
        for (int i = 3; i < 5; i++) begin
            bus_read(32'(i * 4), 0, d, r, rv1, st, rve, tmo);
            model_read(32'(i * 4), ed, er);
            checks++;
            if (tmo || d !== ed || r !== er) begin
                errors++;
                $display("FAIL unmapped_nochange_%0d got %h exp %h", i, d, ed);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] r, er; logic [NC-1:0] w1, w2, ep; logic [31:0] e1, d, ed;
        logic bv1, st, bve, tmo, rv1, rve;
        bus_write(32'h10, 32'h7, 4'hF, 0, r, bv1, w1, w2, e1, st, bve, tmo);
        model_write(32'h10, 32'h7, 4'hF, er, ep);
        req.aw.addr = 32'h10; req.w.data = 32'h9; req.w.strb = 4'hF; req.ar.addr = 32'h10;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (!(rsp.aw_ready && rsp.w_ready && rsp.ar_ready)) begin
            errors++;
            $display("FAIL same_cycle_ready got aw=%b w=%b ar=%b exp 1 1 1",
                     rsp.aw_ready, rsp.w_ready, rsp.ar_ready);
        end
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
        checks++;
        if (rsp.r_valid !== 1'b1 || rsp.r.data !== 32'h7 || rsp.b_valid !== 1'b1 || eoc !== 32'h9) begin
            errors++;
            $display("FAIL same_cycle got rv=%b rdata=%h bv=%b eoc=%h exp 1 7 1 9",
                     rsp.r_valid, rsp.r.data, rsp.b_valid, eoc);
        end
        model_write(32'h10, 32'h9, 4'hF, er, ep);
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        @(posedge clk); #1;
        req.b_ready = 1'b0; req.r_ready = 1'b0;
        bus_read(32'h10, 0, d, r, rv1, st, rve, tmo);
        model_read(32'h10, ed, er);
        checks++;
        if (tmo || d !== ed) begin
            errors++;
            $display("FAIL same_cycle_after got %h exp %h", d, ed);
        end
    endtask

    task automatic test_random();
        logic [1:0] r, er; logic [NC-1:0] w1, w2, ep; logic [31:0] e1, d, ed, rnd, a, v;
        logic [3:0] s; logic bv1, st, bve, tmo, rv1, rve; int unsigned off, sel;
        for (int it = 0; it < 80; it++) begin
            rnd = $urandom();
            sel = $urandom_range(0, 9);
            off = (sel < 7) ? $urandom_range(0, 5) : $urandom_range(0, 63);
            a   = {rnd[31:8], 6'(off), rnd[1:0]};
            if ($urandom_range(0, 1) == 1) begin
                sel = $urandom_range(0, 3);
                v   = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? $urandom() : $urandom_range(0, 400);
                s   = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'hF;
                bus_write(a, v, s, $urandom_range(0, 2), r, bv1, w1, w2, e1, st, bve, tmo);
                model_write(a, v, s, er, ep);
                checks++;
                if (tmo || r !== er || bv1 !== 1'b1 || !st || bve !== 1'b0 ||
                    w1 !== ep || w2 !== '0 || e1 !== m_eoc) begin
                    errors++;
                    $display("FAIL rnd_write_%0d a=%h v=%h s=%h got resp=%b wake=%h eoc=%h exp resp=%b wake=%h eoc=%h",
                             it, a, v, s, r, w1, e1, er, ep, m_eoc);
                end
            end else begin
                bus_read(a, $urandom_range(0, 2), d, r, rv1, st, rve, tmo);
                model_read(a, ed, er);
                checks++;
                if (tmo || d !== ed || r !== er || rv1 !== 1'b1 || !st || rve !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_read_%0d a=%h got %h/%b exp %h/%b", it, a, d, r, ed, er);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; logic rv1, st, rve, tmo;
        req.aw.addr = 32'h10; req.w.data = 32'h3; req.w.strb = 4'hF; req.ar.addr = 32'h10;
        req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
        checks++;
        if (rsp.b_valid !== 1'b1 || rsp.r_valid !== 1'b1 || eoc !== 32'h3) begin
            errors++;
            $display("FAIL pre_reset got bv=%b rv=%b eoc=%h exp 1 1 3", rsp.b_valid, rsp.r_valid, eoc);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_wake = '0; m_eoc = '0;
        checks++;
        if (rsp.b_valid !== 1'b0 || rsp.r_valid !== 1'b0 || rsp.ar_ready !== 1'b1 ||
            eoc !== 32'h0 || eoc_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got bv=%b rv=%b ar=%b eoc=%h exp 0 0 1 0",
                     rsp.b_valid, rsp.r_valid, rsp.ar_ready, eoc);
        end
        // Write to WAKE_UP on the same edge as reset: no pulse may escape.
        req.aw.addr = 32'h0C; req.w.data = 32'h3; req.aw_valid = 1'b1; req.w_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
        checks++;
        if (wake !== '0 || rsp.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wake got wake=%h bv=%b exp 0 0", wake, rsp.b_valid);
        end
        bus_read(32'h0C, 0, d, r, rv1, st, rve, tmo);
        checks++;
        if (tmo || d !== 32'h0 || r !== 2'b00) begin
            errors++;
            $display("FAIL reset_wake_reg got %h/%b exp 0/00", d, r);
        end
    endtask

    initial begin
        test_reset();
        test_ro_reads();
        test_wake();
        test_eoc();
        test_lone_valid();
        test_unmapped();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
